gppcu_instr_issue: RTL and testbench

Instruction issue unit sitting directly upstream of the GPPCU core. On a host start command it streams a contiguous block of instructions from a synchronous-read instruction memory into a small prefetch FIFO. It presents them to the core over a valid/ready handshake and signals completion once every instruction has been accepted. Back-pressure from the core's stall logic (ready low) is absorbed without losing or duplicating instructions.

---
 rtl/gppcu_instr_issue.sv | 165 ++++++++++++++++
 tb/tb_gppcu_instr_issue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_instr_issue.sv
// gppcu_instr_issue: streams a block of instructions from a synchronous-read
// instruction memory through a small prefetch FIFO to the GPPCU core over a
// valid/ready handshake, with credit-based fetch so the FIFO never overflows.
module gppcu_instr_issue #(
    parameter int unsigned DBW        = 32,
    parameter int unsigned ABW        = 10,
    parameter int unsigned CBW        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           iACLK,
    input  logic           iRST,
    input  logic           iSTART,
    input  logic [ABW-1:0] iSTART_ADDR,
    input  logic [CBW-1:0] iSTART_COUNT,
    input  logic           iABORT,
    output logic           oBUSY,
    output logic           oDONE,
    output logic [CBW-1:0] oISSUED_COUNT,
    output logic [ABW-1:0] oIMEM_ADDR,
    output logic           oIMEM_RD,
    input  logic [DBW-1:0] iIMEM_RDATA,
    output logic [DBW-1:0] oINSTR,
    output logic           oINSTR_VALID,
    input  logic           iINSTR_READY
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DepthW = FIFO_DEPTH[PW+1:0];

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [ABW-1:0] addr_q, addr_d;
    logic [CBW-1:0] remain_q, remain_d;
    logic [CBW-1:0] target_q, target_d;
    logic [CBW-1:0] issued_q, issued_d;
    logic           inflight_q, inflight_d;
    logic           done_q, done_d;
    logic [PW:0]    wptr_q, wptr_d;
    logic [PW:0]    rptr_q, rptr_d;
    logic [DBW-1:0] fifo_q [FIFO_DEPTH];

    logic           in_run;
    logic [PW:0]    occ;
    logic [PW+1:0]  pending;
    logic           fifo_empty;
    logic           imem_rd;
    logic           push;
    logic           xfer;
    logic           last_xfer;

    // Handshake, credit and transfer qualifiers
    always_comb begin
        in_run     = (state_q == StRun);
        occ        = wptr_q - rptr_q;
        // Credits count both stored entries and the read whose data arrives next edge
        pending    = {1'b0, occ} + {{(PW + 1){1'b0}}, inflight_q};
        fifo_empty = (occ == '0);
        imem_rd    = in_run && !iABORT && (remain_q != '0) && (pending < DepthW);
        push       = in_run && !iABORT && inflight_q;
        xfer       = in_run && !iABORT && !fifo_empty && iINSTR_READY;
        last_xfer  = xfer && ((issued_q + CBW'(1)) == target_q);
    end

    // State register
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (iSTART && (iSTART_COUNT != '0)) state_d = StRun;
            StRun:  if (iABORT || last_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: run setup, fetch pointer/credits, FIFO pointers, counters
    always_comb begin
        addr_d     = addr_q;
        remain_d   = remain_q;
        target_d   = target_q;
        issued_d   = issued_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (!in_run) begin
            if (iSTART) begin
                addr_d   = iSTART_ADDR;
                remain_d = iSTART_COUNT;
                target_d = iSTART_COUNT;
                issued_d = '0;
                // An empty run completes immediately without touching memory
                done_d   = (iSTART_COUNT == '0);
            end
        end else if (iABORT) begin
            // Flush FIFO and drop any read in flight; issued count is kept
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            inflight_d = imem_rd;
            if (imem_rd) begin
                addr_d   = addr_q + ABW'(1);
                remain_d = remain_q - CBW'(1);
            end
            if (push) wptr_d = wptr_q + (PW + 1)'(1);
            if (xfer) begin
                rptr_d   = rptr_q + (PW + 1)'(1);
                issued_d = issued_q + CBW'(1);
            end
            done_d = last_xfer;
        end
    end

    // Datapath registers
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            addr_q     <= '0;
            remain_q   <= '0;
            target_q   <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            target_q   <= target_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // FIFO storage; returned read data lands at the tail
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wptr_q[PW-1:0]] <= iIMEM_RDATA;
        end
    end

    // Outputs; instruction bus reads zero whenever nothing is presented
    always_comb begin
        oBUSY         = in_run;
        oDONE         = done_q;
        oISSUED_COUNT = issued_q;
        oIMEM_ADDR    = addr_q;
        oIMEM_RD      = imem_rd;
        oINSTR_VALID  = !fifo_empty;
        oINSTR        = fifo_empty ? '0 : fifo_q[rptr_q[PW-1:0]];
    end

endmodule

// File: tb/tb_gppcu_instr_issue.sv
// Directed bench for gppcu_instr_issue with a synchronous-read memory model.
module tb_gppcu_instr_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic [15:0] start_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] issued;
    logic [9:0]  imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    int n_checks = 0;
    int n_fail   = 0;

    gppcu_instr_issue dut (
        .iACLK         (clk),
        .iRST          (rst),
        .iSTART        (start),
        .iSTART_ADDR   (start_addr),
        .iSTART_COUNT  (start_count),
        .iABORT        (abort),
        .oBUSY         (busy),
        .oDONE         (done),
        .oISSUED_COUNT (issued),
        .oIMEM_ADDR    (imem_addr),
        .oIMEM_RD      (imem_rd),
        .iIMEM_RDATA   (imem_rdata),
        .oINSTR        (instr),
        .oINSTR_VALID  (instr_valid),
        .iINSTR_READY  (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hA500_0000 | {22'h0, a} | ({22'h0, a} << 16);
    endfunction

    // Memory model: one-cycle read latency
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem_word(imem_addr);
    end

    // Monitor: log reads, transfers, done pulses, and any change of a stalled head
    logic [9:0]  rd_log[$];
    int          rd_cyc[$];
    logic [31:0] rx_log[$];
    int          rx_cyc[$];
    int          cyc_cnt  = 0;
    int          done_cnt = 0;
    int          hold_err = 0;
    logic        stalled  = 1'b0;
    logic [31:0] prev_instr = '0;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (imem_rd) begin
            rd_log.push_back(imem_addr);
            rd_cyc.push_back(cyc_cnt);
        end
        if (instr_valid && instr_ready) begin
            rx_log.push_back(instr);
            rx_cyc.push_back(cyc_cnt);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (stalled && instr_valid && (instr !== prev_instr)) hold_err <= hold_err + 1;
        stalled    <= instr_valid && !instr_ready;
        prev_instr <= instr;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [9:0] a, input logic [15:0] c);
        start       = 1'b1;
        start_addr  = a;
        start_count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit rnd, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            tick();
            cyc++;
            if (rnd) instr_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Count received words from index base that differ from consecutive memory words
    function automatic int rx_errors(input int base, input logic [9:0] a, input int n);
        int bad = 0;
        if (rx_log.size() != base + n) return n + 1;
        for (int i = 0; i < n; i++) begin
            if (rx_log[base + i] !== mem_word(a + 10'(i))) bad++;
        end
        return bad;
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},   32'(busy), 32'd0);
        chk({pfx, "_done"},   32'(done), 32'd0);
        chk({pfx, "_issued"}, 32'(issued), 32'd0);
        chk({pfx, "_rd"},     32'(imem_rd), 32'd0);
        chk({pfx, "_addr"},   32'(imem_addr), 32'd0);
        chk({pfx, "_valid"},  32'(instr_valid), 32'd0);
        chk({pfx, "_instr"},  instr, 32'd0);
    endtask

    initial begin
        int cyc;
        int brd;
        int brx;
        int bdone;
        int k;

        rst = 1'b1; start = 1'b0; start_addr = '0; start_count = '0;
        abort = 1'b0; instr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");

        // Basic stream of three
        brd = rd_log.size(); brx = rx_log.size(); bdone = done_cnt;
        start_run(10'h010, 16'd3);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_rd", 32'(imem_rd), 32'd1);
        chk("basic_addr", 32'(imem_addr), 32'h010);
        wait_done(20, 1'b0, cyc);
        chk("basic_done_lat", 32'(cyc), 32'd5);
        chk("basic_busy_fall", 32'(busy), 32'd0);
        chk("basic_issued", 32'(issued), 32'd3);
        chk("basic_rd_n", 32'(rd_log.size() - brd), 32'd3);
        if (rd_log.size() - brd == 3) begin
            chk("basic_rd0", 32'(rd_log[brd]), 32'h010);
            chk("basic_rd2", 32'(rd_log[brd + 2]), 32'h012);
            chk("basic_rd_consec", 32'(rd_cyc[brd + 2] - rd_cyc[brd]), 32'd2);
        end
        chk("basic_rx", 32'(rx_errors(brx, 10'h010, 3)), 32'd0);
        if (rx_log.size() - brx == 3)
            chk("basic_rx_consec", 32'(rx_cyc[brx + 2] - rx_cyc[brx]), 32'd2);
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);
        chk("basic_done_cnt", 32'(done_cnt - bdone), 32'd1);

        // Back-pressure: ready low for 6 cycles after first valid
        brd = rd_log.size(); brx = rx_log.size();
        instr_ready = 1'b0;
        start_run(10'h040, 16'd8);
        k = 0;
        while (!instr_valid && k < 10) begin
            tick();
            k++;
        end
        chk("bp_first_valid_lat", 32'(k), 32'd2);
        chk("bp_head", instr, mem_word(10'h040));
        repeat (6) tick();
        chk("bp_reads_stalled", 32'(rd_log.size() - brd), 32'd4);
        chk("bp_rd_off", 32'(imem_rd), 32'd0);
        chk("bp_head_held", instr, mem_word(10'h040));
        instr_ready = 1'b1;
        wait_done(50, 1'b0, cyc);
        chk("bp_issued", 32'(issued), 32'd8);
        chk("bp_rx", 32'(rx_errors(brx, 10'h040, 8)), 32'd0);
        chk("bp_hold", 32'(hold_err), 32'd0);
        tick();

        // Pseudo-random ready over 100 instructions
        brx = rx_log.size(); bdone = done_cnt;
        start_run(10'h100, 16'd100);
        wait_done(2000, 1'b1, cyc);
        instr_ready = 1'b1;
        chk("rnd_done_seen", 32'(done), 32'd1);
        chk("rnd_issued", 32'(issued), 32'd100);
        chk("rnd_rx", 32'(rx_errors(brx, 10'h100, 100)), 32'd0);
        chk("rnd_hold", 32'(hold_err), 32'd0);
        tick();
        chk("rnd_done_cnt", 32'(done_cnt - bdone), 32'd1);

        // Address wrap
        brd = rd_log.size(); brx = rx_log.size();
        start_run(10'h3FE, 16'd4);
        wait_done(20, 1'b0, cyc);
        chk("wrap_rd_n", 32'(rd_log.size() - brd), 32'd4);
        if (rd_log.size() - brd == 4) begin
            chk("wrap_rd0", 32'(rd_log[brd]), 32'h3FE);
            chk("wrap_rd1", 32'(rd_log[brd + 1]), 32'h3FF);
            chk("wrap_rd2", 32'(rd_log[brd + 2]), 32'h000);
            chk("wrap_rd3", 32'(rd_log[brd + 3]), 32'h001);
        end
        chk("wrap_rx", 32'(rx_errors(brx, 10'h3FE, 4)), 32'd0);
        tick();

        // Zero count
        brd = rd_log.size(); bdone = done_cnt;
        start_run(10'h000, 16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_rd", 32'(imem_rd), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(done), 32'd0);
        chk("zero_no_reads", 32'(rd_log.size() - brd), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt - bdone), 32'd1);

        // Start held high through a run is ignored
        brd = rd_log.size(); brx = rx_log.size();
        start = 1'b1; start_addr = 10'h020; start_count = 16'd5;
        tick();
        start_addr = 10'h300; start_count = 16'd9;
        wait_done(30, 1'b0, cyc);
        start = 1'b0;
        chk("held_issued", 32'(issued), 32'd5);
        chk("held_reads", 32'(rd_log.size() - brd), 32'd5);
        chk("held_rx", 32'(rx_errors(brx, 10'h020, 5)), 32'd0);
        tick();

        // Abort with FIFO nearly full and a read in flight
        bdone = done_cnt;
        start_run(10'h080, 16'd10);
        repeat (4) tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        chk("abort_pre_valid", 32'(instr_valid), 32'd1);
        chk("abort_pre_credit", 32'(imem_rd), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_issued_held", 32'(issued), 32'd2);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt - bdone), 32'd0);
        chk("abort_still_empty", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        brx = rx_log.size();
        start_run(10'h050, 16'd3);
        wait_done(20, 1'b0, cyc);
        chk("abort_restart_issued", 32'(issued), 32'd3);
        chk("abort_restart_rx", 32'(rx_errors(brx, 10'h050, 3)), 32'd0);
        tick();

        // Same scenario, ended by reset
        start_run(10'h080, 16'd10);
        repeat (4) tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst_mid");
        instr_ready = 1'b1;
        brx = rx_log.size();
        start_run(10'h060, 16'd2);
        wait_done(20, 1'b0, cyc);
        chk("rst_restart_issued", 32'(issued), 32'd2);
        chk("rst_restart_rx", 32'(rx_errors(brx, 10'h060, 2)), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
